cordic_vec: RTL and testbench

Iterative vectoring-mode CORDIC: the inverse of the pipelined rotation CORDIC in the same datapath.
- Takes a Cartesian vector (x, y).
- Returns its CORDIC-gain-scaled magnitude and its angle atan2(y, x).
- Angle uses the same binary-angle format as the rotation block, so the rotator can consume it directly.
- Sits behind demodulator/phase-detector logic and uses a valid/ready handshake on both sides.

---
 rtl/cordic_vec.sv | 201 ++++++++++++++++++++
 tb/tb_cordic_vec.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/cordic_vec.sv
// Iterative vectoring-mode CORDIC: (x, y) -> K-scaled magnitude and atan2(y, x)
// as a binary angle (full circle = 2^ZWIDTH). Valid/ready handshake on both sides.
// Optional gain compensation is enabled by defining CORDIC_VEC_GAINCOMP_EN.
//
// state  | meaning
// IDLE   | in_ready=1, waiting for an input vector
// ITER   | one micro-rotation per cycle; final cycle commits result registers
// SCALE  | (gain-comp build only) multiply magnitude by 1/K
// DONE   | out_valid=1, outputs held until out_ready
module cordic_vec #(
  parameter int XYWIDTH = 16,
  parameter int ZWIDTH  = 32,
  parameter int ITER    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XYWIDTH-1:0] x_in,
  input  logic [XYWIDTH-1:0] y_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XYWIDTH:0]   mag_out,
  output logic [ZWIDTH-1:0]  ang_out
);

  localparam int XW = XYWIDTH + 2;
  localparam int CW = $clog2(ITER + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ITER);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_DONE
`ifdef CORDIC_VEC_GAINCOMP_EN
    , S_SCALE
`endif
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]        cnt_q;
  logic signed [XW-1:0] x_q, y_q;
  logic [ZWIDTH-1:0]    z_q;
  logic                 zero_q;
  logic [XYWIDTH:0]     mag_q;
  logic [ZWIDTH-1:0]    ang_q;

  // atan(2^-i) scaled to a 2^32 full circle, rescaled (with rounding) to ZWIDTH
  function automatic logic [ZWIDTH-1:0] atan_val(input int i);
    logic [63:0] v;
    int sh;
    case (i)
      0:  v = 64'h2000_0000;  1:  v = 64'h12E4_051E;
      2:  v = 64'h09FB_385B;  3:  v = 64'h0511_11D4;
      4:  v = 64'h028B_0D43;  5:  v = 64'h0145_D7E1;
      6:  v = 64'h00A2_F61E;  7:  v = 64'h0051_7C55;
      8:  v = 64'h0028_BE53;  9:  v = 64'h0014_5F2F;
      10: v = 64'h000A_2F98;  11: v = 64'h0005_17CC;
      12: v = 64'h0002_8BE6;  13: v = 64'h0001_45F3;
      14: v = 64'h0000_A2FA;  15: v = 64'h0000_517D;
      16: v = 64'h0000_28BE;  17: v = 64'h0000_145F;
      18: v = 64'h0000_0A30;  19: v = 64'h0000_0518;
      20: v = 64'h0000_028C;  21: v = 64'h0000_0146;
      22: v = 64'h0000_00A3;  23: v = 64'h0000_0051;
      24: v = 64'h0000_0029;  25: v = 64'h0000_0014;
      26: v = 64'h0000_000A;  27: v = 64'h0000_0005;
      28: v = 64'h0000_0003;  29: v = 64'h0000_0001;
      30: v = 64'h0000_0001;
      default: v = 64'd0;
    endcase
    sh = 32 - ZWIDTH;
    if (sh > 0) v = (v + (64'd1 << (sh - 1))) >> sh;
    else if (sh < 0) v = v << (-sh);
    return v[ZWIDTH-1:0];
  endfunction

  // quadrant pre-rotation so the vector starts in the right half-plane;
  // the two guard bits make negating the most negative input safe
  logic signed [XW-1:0] x_ext, y_ext, cap_x, cap_y;
  logic [ZWIDTH-1:0]    cap_z;
  localparam logic [ZWIDTH-1:0] QUARTER = {2'b01, {(ZWIDTH-2){1'b0}}};

  assign x_ext = {{2{x_in[XYWIDTH-1]}}, x_in};
  assign y_ext = {{2{y_in[XYWIDTH-1]}}, y_in};

  // select pre-rotated capture values from the input quadrant
  always_comb begin
    cap_x = x_ext;
    cap_y = y_ext;
    cap_z = '0;
    if (x_in[XYWIDTH-1]) begin
      if (!y_in[XYWIDTH-1]) begin
        cap_x = y_ext;
        cap_y = -x_ext;
        cap_z = QUARTER;
      end else begin
        cap_x = -y_ext;
        cap_y = x_ext;
        cap_z = -QUARTER;
      end
    end
  end

  logic signed [XW-1:0] x_sh, y_sh;
  logic [ZWIDTH-1:0]    atan_i;
  assign x_sh   = x_q >>> cnt_q;
  assign y_sh   = y_q >>> cnt_q;
  assign atan_i = atan_val(int'(cnt_q));

`ifdef CORDIC_VEC_GAINCOMP_EN
  // 39797 = round(2^16 / K)
  logic [XYWIDTH+16:0] prod;
  assign prod = {16'd0, mag_q} * {{(XYWIDTH+1){1'b0}}, 16'd39797};
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // next-state and handshake outputs
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_ITER;
      end
      S_ITER: begin
`ifdef CORDIC_VEC_GAINCOMP_EN
        if (cnt_q == CNT_LAST) state_d = S_SCALE;
`else
        if (cnt_q == CNT_LAST) state_d = S_DONE;
`endif
      end
`ifdef CORDIC_VEC_GAINCOMP_EN
      S_SCALE: state_d = S_DONE;
`endif
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // datapath: capture, micro-rotations, then registered result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      zero_q <= 1'b0;
      mag_q  <= '0;
      ang_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            x_q    <= cap_x;
            y_q    <= cap_y;
            z_q    <= cap_z;
            cnt_q  <= '0;
            zero_q <= (x_in == '0) && (y_in == '0);
          end
        end
        S_ITER: begin
          if (cnt_q != CNT_LAST) begin
            if (!y_q[XW-1]) begin
              x_q <= x_q + y_sh;
              y_q <= y_q - x_sh;
              z_q <= z_q + atan_i;
            end else begin
              x_q <= x_q - y_sh;
              y_q <= y_q + x_sh;
              z_q <= z_q - atan_i;
            end
            cnt_q <= cnt_q + CW'(1);
          end else begin
            // zero input would otherwise accumulate a meaningless angle
            mag_q <= zero_q ? '0 : x_q[XYWIDTH:0];
            ang_q <= zero_q ? '0 : z_q;
          end
        end
`ifdef CORDIC_VEC_GAINCOMP_EN
        S_SCALE: mag_q <= (XYWIDTH+1)'(prod >> 16);
`endif
        default: ;
      endcase
    end
  end

  assign mag_out = mag_q;
  assign ang_out = ang_q;

endmodule

// File: tb/tb_cordic_vec.sv
// Directed bench for cordic_vec with hand-computed expected magnitudes/angles.
module tb_cordic_vec;

`ifdef CORDIC_VEC_GAINCOMP_EN
  localparam int LAT = 18;
`else
  localparam int LAT = 17;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] x_in = '0;
  logic [15:0] y_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [16:0] mag_out;
  logic [31:0] ang_out;

  int errors = 0;
  int checks = 0;

  cordic_vec #(.XYWIDTH(16), .ZWIDTH(32), .ITER(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .out_valid(out_valid), .out_ready(out_ready),
    .mag_out(mag_out), .ang_out(ang_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input int obs, input int exp, input int tol);
    checks++;
    assert ((obs - exp) <= tol && (exp - obs) <= tol) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d +/-%0d", tag, obs, exp, tol);
    end
  endtask

  task automatic chk_ang(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    logic signed [31:0] d;
    d = obs - exp;
    checks++;
    assert (d >= -32768 && d <= 32768) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h +/-2^15", tag, obs, exp);
    end
  endtask

  task automatic send(input string tag, input logic [15:0] xv, input logic [15:0] yv);
    @(negedge clk);
    chk({tag, " in_ready before accept"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    x_in = xv;
    y_in = yv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, " latency"}, 64'(n), 64'(LAT));
  endtask

  task automatic release_out(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, " in_ready after accept"}, 64'(in_ready), 64'd1);
    chk({tag, " out_valid after accept"}, 64'(out_valid), 64'd0);
  endtask

  task automatic run_vec(input string tag, input logic [15:0] xv, input logic [15:0] yv,
                         input int emag, input int mtol, input logic [31:0] eang);
    send(tag, xv, yv);
    wait_out(tag);
    chk_tol({tag, " mag"}, int'(mag_out), emag, mtol);
    chk_ang({tag, " ang"}, ang_out, eang);
    release_out(tag);
  endtask

`ifdef CORDIC_VEC_GAINCOMP_EN
  localparam int M16K = 16384, M16K_T = 4;
  localparam int MDIAG = 46341, MDIAG_T = 6;
  localparam int M32K = 32768, M32K_T = 4;
`else
  localparam int M16K = 26981, M16K_T = 4;
  localparam int MDIAG = 76315, MDIAG_T = 8;
  localparam int M32K = 53962, M32K_T = 6;
`endif

  initial begin
    logic [16:0] held_mag;
    logic [31:0] held_ang;

    // reset state
    #12;
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset mag", 64'(mag_out), 64'd0);
    chk("reset ang", 64'(ang_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // axis, quadrant and boundary vectors
    run_vec("pos_x",   16'sd16384,  16'sd0,      M16K,  M16K_T,  32'h0000_0000);
    run_vec("pos_y",   16'sd0,      16'sd16384,  M16K,  M16K_T,  32'h4000_0000);
    run_vec("neg_x",   -16'sd16384, 16'sd0,      M16K,  M16K_T,  32'h8000_0000);
    run_vec("diag_q3", 16'h8000,    16'h8000,    MDIAG, MDIAG_T, 32'hA000_0000);
    run_vec("zero",    16'sd0,      16'sd0,      0,     0,       32'h0000_0000);
    chk("zero ang exact", 64'(ang_out), 64'd0);
    run_vec("min_x",   16'h8000,    16'sd0,      M32K,  M32K_T,  32'h8000_0000);

    // back-pressure: outputs held, new input ignored
    send("hold", 16'sd0, 16'sd16384);
    wait_out("hold");
    held_mag = mag_out;
    held_ang = ang_out;
    chk_tol("hold mag", int'(held_mag), M16K, M16K_T);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      x_in = 16'sd100;
      y_in = -16'sd100;
      @(posedge clk);
      #1;
      chk("hold out_valid", 64'(out_valid), 64'd1);
      chk("hold in_ready", 64'(in_ready), 64'd0);
      chk("hold mag stable", 64'(mag_out), 64'(held_mag));
      chk("hold ang stable", 64'(ang_out), 64'(held_ang));
    end
    in_valid = 1'b0;
    release_out("hold");
    repeat (LAT + 2) @(posedge clk);
    #1;
    chk("hold no spurious result", 64'(out_valid), 64'd0);

    // asynchronous reset in the middle of iterating
    send("rst_mid", -16'sd16384, 16'sd0);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid in_ready", 64'(in_ready), 64'd1);
    chk("rst_mid mag", 64'(mag_out), 64'd0);
    chk("rst_mid ang", 64'(ang_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec("after_rst", 16'sd0, 16'sd16384, M16K, M16K_T, 32'h4000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
